// File: rtl/dmem_responder.sv
// dmem_responder: load/store target over a word-addressed SRAM with a fixed
// number of wait states; one request in flight, valid/ready on both channels.
module dmem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_WAIT  = 2'd1;
   localparam logic [1:0]  ST_RESP  = 2'd2;
   localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;

   logic [31:0] mem [DEPTH];

   logic             cur_we, cur_signed, acc_err, enter_resp;
   logic [31:0]      cur_addr, cur_wdata, offset, idx_full, rd_word, wr_data;
   logic [1:0]       cur_size, lane;
   logic [3:0]       wr_be;
   logic [IDX_W-1:0] idx;

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  ln,
                                                input logic [1:0]  size,
                                                input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {ln, 3'b000});
      h = ln[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   load_extract = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'b01:   load_extract = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: load_extract = word;
      endcase
   endfunction

   // With zero wait states the request is decoded straight off the port in
   // the accept cycle; otherwise the latched copy is used.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_we     = req_we;
         cur_addr   = req_addr;
         cur_wdata  = req_wdata;
         cur_size   = req_size;
         cur_signed = req_signed;
      end else begin
         cur_we     = we_q;
         cur_addr   = addr_q;
         cur_wdata  = wdata_q;
         cur_size   = size_q;
         cur_signed = signed_q;
      end
   end

   always_comb begin
      offset   = cur_addr - BASE_ADDR;
      idx_full = offset >> 2;
      idx      = idx_full[IDX_W-1:0];
      lane     = cur_addr[1:0];
      acc_err  = (cur_size == 2'b11)
               | ((cur_size == 2'b01) & lane[0])
               | ((cur_size == 2'b10) & (lane != 2'b00))
               | (cur_addr < BASE_ADDR)
               | (idx_full >= 32'(DEPTH));
      case (cur_size)
         2'b00:   begin wr_be = 4'b0001 << lane;                  wr_data = {4{cur_wdata[7:0]}};  end
         2'b01:   begin wr_be = lane[1] ? 4'b1100 : 4'b0011;      wr_data = {2{cur_wdata[15:0]}}; end
         2'b10:   begin wr_be = 4'b1111;                          wr_data = cur_wdata;            end
         default: begin wr_be = 4'b0000;                          wr_data = cur_wdata;            end
      endcase
      rd_word = mem[idx];
   end

   assign enter_resp = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0))
                     || ((state_q == ST_WAIT) && (cnt_q == LAST_CNT));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      signed_d     = signed_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               size_d   = req_size;
               signed_d = req_signed;
               cnt_d    = 4'd0;
               state_d  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (enter_resp) begin
         resp_valid_d = 1'b1;
         resp_err_d   = acc_err;
         resp_rdata_d = (acc_err || cur_we) ? 32'h0
                      : load_extract(rd_word, lane, cur_size, cur_signed);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
   end

   // Stores commit only on RESP entry, so an aborted request never lands.
   always_ff @(posedge clk) begin
      if (rst_n && enter_resp && cur_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic
// checked against a byte-level memory model.
`timescale 1ns/1ps
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam int WAITC = 2;
   localparam int LAT   = WAITC + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] mdl [0:15];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_signed(req_signed),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   // Reference: words 0..15 tracked as plain 32-bit values, accesses computed
   // with shifts/masks and two's-complement arithmetic for sign extension.
   function automatic void model_access(input bit we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [1:0] size,
                                        input bit sgn, output logic [31:0] rd, output bit err);
      int unsigned idx, sh;
      logic [31:0] old, v;
      idx = addr / 4;
      sh  = (addr % 4) * 8;
      err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || idx >= DEPTH;
      rd = 32'h0;
      if (err) return;
      old = mdl[idx % 16];
      if (we) begin
         case (size)
            2'd0:    v = (old & ~(32'hFF << sh))   | ((wdata & 32'hFF) << sh);
            2'd1:    v = (old & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            default: v = wdata;
         endcase
         mdl[idx % 16] = v;
      end else begin
         case (size)
            2'd0: begin v = (old >> sh) & 32'hFF;   if (sgn && v >= 128)   v = v - 256;   end
            2'd1: begin v = (old >> sh) & 32'hFFFF; if (sgn && v >= 32768) v = v - 65536; end
            default: v = old;
         endcase
         rd = v;
      end
   endfunction

   // Drives one request, returns the response and the latency counted in
   // clock edges from (and including) the accept edge; 50+ means timeout.
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit sgn,
                         output logic [31:0] rd, output logic err, output int lat);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_signed = sgn;
      guard = 0;
      while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_size = 2'($urandom); req_signed = 1'($urandom);
      while (!resp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
      rd  = resp_rdata;
      err = resp_err;
      if (!resp_valid) begin rd = 'x; err = 1'bx; end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
      n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
      n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
      @(negedge clk) rst_n = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
   endtask

   task automatic test_init();
      logic [31:0] rd, erd, wd; logic err; bit eerr; int lat;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         model_access(1'b1, 32'(i * 4), wd, 2'd2, 1'b0, erd, eerr);
         do_req(1'b1, 32'(i * 4), wd, 2'd2, 1'b0, rd, err, lat);
         n_cmp++;
         if ({err, rd} !== {1'b0, 32'h0} || lat != LAT) begin
            n_bad++; $display("FAIL init_sw[%0d] got err=%b rd=%h lat=%0d want err=0 rd=0 lat=%0d", i, err, rd, lat, LAT);
         end
      end
   endtask

   task automatic test_word_store_load();
      logic [31:0] rd, erd; logic err; bit eerr; int lat;
      model_access(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, erd, eerr);
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL sw_latency got=%0d want=3", lat); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sw_err got=%b want=0", err); end
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL sw_rdata got=%h want=0", rd); end
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL lw_after_sw got err=%b rd=%h want err=0 rd=deadbeef", err, rd); end
   endtask

   task automatic test_extension();
      logic [31:0] rd, erd; logic err; bit eerr; int lat;
      model_access(1'b1, 32'h10, 32'h80F17F82, 2'd2, 1'b0, erd, eerr);
      do_req(1'b1, 32'h10, 32'h80F17F82, 2'd2, 1'b0, rd, err, lat);
      do_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b1, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'hFFFFFF82}) begin n_bad++; $display("FAIL lb got err=%b rd=%h want ffffff82", err, rd); end
      do_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'h00000082}) begin n_bad++; $display("FAIL lbu got err=%b rd=%h want 00000082", err, rd); end
      do_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'hFFFF80F1}) begin n_bad++; $display("FAIL lh got err=%b rd=%h want ffff80f1", err, rd); end
      do_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'h000080F1}) begin n_bad++; $display("FAIL lhu got err=%b rd=%h want 000080f1", err, rd); end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd, erd; logic err; bit eerr; int lat;
      model_access(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, erd, eerr);
      do_req(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, rd, err, lat);
      model_access(1'b1, 32'h11, 32'hFFFFFFAA, 2'd0, 1'b0, erd, eerr);
      do_req(1'b1, 32'h11, 32'hFFFFFFAA, 2'd0, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL sb_resp got err=%b rd=%h want err=0 rd=0", err, rd); end
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'h1122AA44}) begin n_bad++; $display("FAIL lw_after_sb got err=%b rd=%h want 1122aa44", err, rd); end
      model_access(1'b1, 32'h12, 32'h5555BEEF, 2'd1, 1'b0, erd, eerr);
      do_req(1'b1, 32'h12, 32'h5555BEEF, 2'd1, 1'b0, rd, err, lat);
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'hBEEFAA44}) begin n_bad++; $display("FAIL lw_after_sh got err=%b rd=%h want beefaa44", err, rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic err; int lat;
      do_req(1'b0, 32'h12, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL lw_misaligned got err=%b rd=%h want err=1 rd=0", err, rd); end
      do_req(1'b1, 32'h13, 32'h0000CAFE, 2'd1, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL sh_misaligned got err=%b rd=%h want err=1 rd=0", err, rd); end
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'hBEEFAA44}) begin n_bad++; $display("FAIL mem_after_bad_sh got err=%b rd=%h want beefaa44", err, rd); end
      do_req(1'b0, 32'(DEPTH * 4), 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL lw_out_of_range got err=%b rd=%h want err=1 rd=0", err, rd); end
      do_req(1'b1, 32'(DEPTH * 4), 32'h77, 2'd0, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL sb_out_of_range got err=%b rd=%h want err=1 rd=0", err, rd); end
      do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL lw_top_addr got err=%b rd=%h want err=1 rd=0", err, rd); end
      do_req(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL illegal_size got err=%b rd=%h want err=1 rd=0", err, rd); end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_signed = 1'b0;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready got=%b want=1", req_ready); end
      @(posedge clk);
      #1 req_addr = 32'h12; req_size = 2'd1;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL bp_first_latency got=%0d want=%0d", lat, LAT); end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b1, 1'b0, 32'hBEEFAA44, 1'b0}) begin
            n_bad++; $display("FAIL bp_hold[%0d] got v=%b e=%b rd=%h rdy=%b want v=1 e=0 rd=beefaa44 rdy=0",
                              c, resp_valid, resp_err, resp_rdata, req_ready);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_handshake_ready got=%b want=0", req_ready); end
      @(posedge clk);
      #1 resp_ready = 1'b0;
      n_cmp++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_bad++; $display("FAIL bp_after_handshake got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!resp_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
      n_cmp++;
      if (lat != LAT || {resp_err, resp_rdata} !== {1'b0, 32'h0000BEEF}) begin
         n_bad++; $display("FAIL bp_second got lat=%0d e=%b rd=%h want lat=%0d e=0 rd=0000beef", lat, resp_err, resp_rdata, LAT);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd, erd; logic err; bit eerr; int lat;
      model_access(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, erd, eerr);
      do_req(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, rd, err, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_size = 2'd2; req_signed = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_bad++; $display("FAIL rst_mid_wait got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, err, lat);
      n_cmp++; if ({err, rd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL lw_after_abort got err=%b rd=%h want err=0 rd=0", err, rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, addr, wd; logic err; bit eerr, we, sgn; logic [1:0] size; int lat, r;
      for (int i = 0; i < 300; i++) begin
         we  = 1'($urandom);
         sgn = 1'($urandom);
         wd  = $urandom;
         r   = $urandom_range(0, 7);
         size = (r == 7) ? 2'd3 : 2'(r % 3);
         r = $urandom_range(0, 9);
         if (r == 0)      addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
         else if (r == 1) addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
         else             addr = 32'($urandom_range(0, 63));
         model_access(we, addr, wd, size, sgn, erd, eerr);
         do_req(we, addr, wd, size, sgn, rd, err, lat);
         n_cmp++;
         if ({err, rd} !== {eerr, erd}) begin
            n_bad++; $display("FAIL rand[%0d] we=%b a=%h sz=%0d s=%b got err=%b rd=%h want err=%b rd=%h",
                              i, we, addr, size, sgn, err, rd, eerr, erd);
         end
         n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_word_store_load();
      test_extension();
      test_partial_store();
      test_errors();
      test_backpressure();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
